// File: rtl/protein_assay_sequencer.sv
// Run-time sequencer for the colorimetric protein assay: dispense, mix, per-channel optical readout.
// Optional optical ack timeout enabled by defining OPT_TIMEOUT_EN.
module protein_assay_sequencer #(
    parameter int N_BUF          = 39,
    parameter int N_OPT          = 8,
    parameter int DISP_CYCLES    = 16,
    parameter int MIX_CYCLES     = 64,
    parameter int OPT_W          = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     smp_en,
    output logic [N_BUF-1:0]         buf_en,
    output logic                     opt_req,
    output logic [$clog2(N_OPT)-1:0] opt_sel,
    input  logic                     opt_ack,
    input  logic [OPT_W-1:0]         opt_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_OPT)-1:0] res_ch,
    output logic [OPT_W-1:0]         res_data,
    output logic                     res_err,
    output logic                     busy,
    output logic                     done
);
    localparam int SEL_W = $clog2(N_OPT);
    localparam int MAX_A = (DISP_CYCLES > MIX_CYCLES) ? DISP_CYCLES : MIX_CYCLES;
    localparam int MAX_BOUND = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_BOUND) + 1;
    localparam int CH_W = $clog2(N_OPT) + 1;
    localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISP_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIX_LAST  = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_OPT - 1);

    typedef enum logic [2:0] {IDLE, SAMPLE, BUFFER, MIX, REQ, RESULT, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CH_W-1:0]    ch, ch_nxt;
    logic               smp_nxt, req_nxt, valid_nxt, busy_nxt, done_nxt;
    logic [N_BUF-1:0]   buf_nxt;
    logic [SEL_W-1:0]   sel_nxt, rch_nxt;
    logic [OPT_W-1:0]   rdata_nxt;
    logic               err_q, err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ch        <= '0;
            smp_en    <= 1'b0;
            buf_en    <= '0;
            opt_req   <= 1'b0;
            opt_sel   <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
            err_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ch        <= ch_nxt;
            smp_en    <= smp_nxt;
            buf_en    <= buf_nxt;
            opt_req   <= req_nxt;
            opt_sel   <= sel_nxt;
            res_valid <= valid_nxt;
            res_ch    <= rch_nxt;
            res_data  <= rdata_nxt;
            err_q     <= err_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Outputs are computed from the next state so every output leaves a flop.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ch_nxt    = ch;
        smp_nxt   = smp_en;
        buf_nxt   = buf_en;
        req_nxt   = opt_req;
        valid_nxt = res_valid;
        rch_nxt   = res_ch;
        rdata_nxt = res_data;
        err_nxt   = err_q;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            ch_nxt    = '0;
            smp_nxt   = 1'b0;
            buf_nxt   = '0;
            req_nxt   = 1'b0;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = SAMPLE;
                        cnt_nxt   = '0;
                        smp_nxt   = 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cnt == DISP_LAST) begin
                        state_nxt = BUFFER;
                        cnt_nxt   = '0;
                        smp_nxt   = 1'b0;
                        buf_nxt   = N_BUF'(1);
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                BUFFER: begin
                    if (cnt == DISP_LAST) begin
                        cnt_nxt = '0;
                        if (buf_en[N_BUF-1]) begin
                            state_nxt = MIX;
                            buf_nxt   = '0;
                        end else begin
                            buf_nxt = buf_en << 1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                MIX: begin
                    if (cnt == MIX_LAST) begin
                        state_nxt = REQ;
                        cnt_nxt   = '0;
                        ch_nxt    = '0;
                        req_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                REQ: begin
                    if (opt_ack) begin
                        state_nxt = RESULT;
                        cnt_nxt   = '0;
                        req_nxt   = 1'b0;
                        valid_nxt = 1'b1;
                        rch_nxt   = SEL_W'(ch);
                        rdata_nxt = opt_data;
                        err_nxt   = 1'b0;
`ifdef OPT_TIMEOUT_EN
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt = RESULT;
                        cnt_nxt   = '0;
                        req_nxt   = 1'b0;
                        valid_nxt = 1'b1;
                        rch_nxt   = SEL_W'(ch);
                        rdata_nxt = '1;
                        err_nxt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
`endif
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        valid_nxt = 1'b0;
                        if (ch == CH_LAST) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = REQ;
                            ch_nxt    = ch + 1'b1;
                            cnt_nxt   = '0;
                            req_nxt   = 1'b1;
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
        busy_nxt = (state_nxt != IDLE);
        sel_nxt  = SEL_W'(ch_nxt);
    end

`ifdef OPT_TIMEOUT_EN
    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_protein_assay_sequencer.sv
// Directed bench for protein_assay_sequencer; timeout cases run when OPT_TIMEOUT_EN is defined.
module tb_protein_assay_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, abort, opt_ack, res_ready;
    logic [11:0] opt_data;
    logic        smp_en, opt_req, res_valid, res_err, busy, done;
    logic [2:0]  buf_en;
    logic [0:0]  opt_sel, res_ch;
    logic [11:0] res_data;
    int          checks = 0;
    int          errors = 0;

    protein_assay_sequencer #(
        .N_BUF(3), .N_OPT(2), .DISP_CYCLES(4), .MIX_CYCLES(8), .OPT_W(12), .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .smp_en(smp_en), .buf_en(buf_en), .opt_req(opt_req), .opt_sel(opt_sel),
        .opt_ack(opt_ack), .opt_data(opt_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_data(res_data), .res_err(res_err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a run from IDLE and check every cycle of the dispense/mix window (cycles 1..25).
    task automatic dispense(input bit poke_mix);
        logic [3:0] exp;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            exp = (c <= 4) ? 4'b1000 : (c <= 8) ? 4'b0001 : (c <= 12) ? 4'b0010 :
                  (c <= 16) ? 4'b0100 : 4'b0000;
            check($sformatf("en_c%0d", c), {smp_en, buf_en}, exp);
            if (c == 1 || c == 20) check($sformatf("busy_c%0d", c), busy, 1);
            check($sformatf("req_c%0d", c), opt_req, 0);
            start = (poke_mix && c == 20);
            step();
        end
        start = 1'b0;
        check("req_c25", opt_req, 1);
        check("sel_c25", opt_sel, 0);
        check("valid_c25", res_valid, 0);
    endtask

    // Readout of both channels; bp = stall cycles on ch0, mode 0/1/2 = ch1 acked after 2 / never / on timeout cycle.
    task automatic readout(input int bp, input int mode, input logic [11:0] d0, input logic [11:0] d1);
        logic [11:0] exp1;
        step();
        step();
        opt_ack = 1'b1;
        opt_data = d0;
        res_ready = (bp == 0);
        step();
        opt_ack = 1'b0;
        opt_data = 12'h000;
        check("r0_valid", res_valid, 1);
        check("r0_ch", res_ch, 0);
        check("r0_data", res_data, d0);
        check("r0_err", res_err, 0);
        check("r0_req", opt_req, 0);
        for (int i = 0; i < bp; i++) begin
            check($sformatf("bp%0d_valid", i), res_valid, 1);
            check($sformatf("bp%0d_data", i), res_data, d0);
            check($sformatf("bp%0d_ch", i), res_ch, 0);
            check($sformatf("bp%0d_req", i), opt_req, 0);
            step();
        end
        check("r0_hold_valid", res_valid, 1);
        res_ready = 1'b1;
        step();
        check("req1_valid", res_valid, 0);
        check("req1_req", opt_req, 1);
        check("req1_sel", opt_sel, 1);
        if (mode == 0) begin
            step();
            step();
            opt_ack = 1'b1;
            opt_data = d1;
            step();
        end else begin
            for (int k = 1; k <= 9; k++) step();
            check("req1_late_req", opt_req, 1);
            check("req1_late_valid", res_valid, 0);
            if (mode == 2) begin
                opt_ack = 1'b1;
                opt_data = d1;
            end
            step();
        end
        opt_ack = 1'b0;
        opt_data = 12'h000;
        exp1 = (mode == 1) ? 12'hFFF : d1;
        check("r1_valid", res_valid, 1);
        check("r1_ch", res_ch, 1);
        check("r1_data", res_data, exp1);
        check("r1_err", res_err, (mode == 1) ? 1 : 0);
        check("r1_req", opt_req, 0);
        step();
        check("done_pulse", done, 1);
        check("done_valid", res_valid, 0);
        step();
        check("done_low", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        opt_ack = 1'b0;
        opt_data = 12'h000;
        res_ready = 1'b1;
        step();
        step();
        check("rst_en", {smp_en, buf_en}, 0);
        check("rst_req", opt_req, 0);
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", res_data, 0);
        check("rst_err", res_err, 0);
        rst_n = 1'b1;
        step();

        dispense(0);
        readout(0, 0, 12'h5A3, 12'h0C7);

        dispense(0);
        readout(5, 0, 12'h321, 12'hABC);

        // Abort while buf_en = 010.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("ab_pre_en", {smp_en, buf_en}, 4'b0010);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_en", {smp_en, buf_en}, 0);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        step();
        check("ab_busy2", busy, 0);
        check("ab_done2", done, 0);
        dispense(0);
        readout(0, 0, 12'h777, 12'h888);

        // start+abort together in IDLE, then start pulsed during MIX.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 0);
        check("sa_smp", smp_en, 0);
        step();
        check("sa_busy2", busy, 0);
        dispense(1);
        readout(0, 0, 12'h0F0, 12'hF0F);

`ifdef OPT_TIMEOUT_EN
        dispense(0);
        readout(0, 1, 12'h123, 12'h456);
        dispense(0);
        readout(0, 2, 12'h234, 12'h567);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
